// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with fetch/memory timeout
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic [2:0]  flags,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        pc_br_reg,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [3:0]  alu_op,
    output logic [2:0]  flag_we,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    // Last not-ready cycle still tolerated before giving up on a request.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic [3:0]  ir_op;
    logic [2:0]  ir_cond;
    logic        br_taken;

    // Operand fields are consumed by the datapath, not by this controller.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^instr[8:0];

    // State register, wait counter and the opcode/condition part of the IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            ir_op    <= 4'd0;
            ir_cond  <= 3'd0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= 8'd0;
            end else if ((state == S_FETCH && !imem_ready) ||
                         (state == S_MEM && !dmem_ready)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == S_FETCH && imem_ready) begin
                ir_op   <= instr[15:12];
                ir_cond <= instr[11:9];
            end
        end
    end

    // Branch condition evaluated on the live {Z,V,N} flags.
    always_comb begin
        br_taken = 1'b0;
        case (ir_cond)
            3'b000: br_taken = !flags[2];
            3'b001: br_taken = flags[2];
            3'b010: br_taken = !flags[2] && !flags[0];
            3'b011: br_taken = flags[0];
            3'b100: br_taken = flags[2] || (!flags[2] && !flags[0]);
            3'b101: br_taken = flags[0] || flags[2];
            3'b110: br_taken = flags[1];
            default: br_taken = 1'b1;
        endcase
    end

    // Next-state and output decode; only ir_load and transitions see ready.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        pc_br_reg  = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = 2'b00;
        alu_op     = 4'd0;
        flag_we    = 3'b000;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        case (state)
            S_FETCH: begin
                // Held reset keeps the fetch request quiet until release.
                imem_req = !rst;
                ir_load  = imem_ready && !rst;
                if (imem_ready) begin
                    next_state = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_ERR;
                end
            end
            S_DECODE: begin
                if (ir_op == OP_HLT) begin
                    next_state = S_HALT;
                end else begin
                    pc_inc     = 1'b1;
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = ir_op;
                case (ir_op)
                    4'b0000, 4'b0001:                   flag_we = 3'b111;
                    4'b0010, 4'b0100, 4'b0101, 4'b0110: flag_we = 3'b100;
                    default:                            flag_we = 3'b000;
                endcase
                if (ir_op == OP_B || ir_op == OP_BR) begin
                    pc_branch  = br_taken;
                    pc_br_reg  = br_taken && (ir_op == OP_BR);
                    next_state = S_FETCH;
                end else if (ir_op == OP_LW || ir_op == OP_SW) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (ir_op == OP_SW);
                if (dmem_ready) begin
                    next_state = (ir_op == OP_SW) ? S_FETCH : S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = S_ERR;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                if (ir_op == OP_LW) begin
                    wb_sel = 2'b01;
                end else if (ir_op == OP_PCS) begin
                    wb_sel = 2'b10;
                end else if (ir_op == 4'b1010 || ir_op == 4'b1011) begin
                    wb_sel = 2'b11;
                end
                next_state = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_ERR:  err    = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

endmodule
